// File: rtl/axi_lite_mem_slave_pkg.sv
// Shared constants, FSM encodings and address-window helper for the AXI4-Lite memory slave.
package axi_lite_pkg;

  localparam logic [2:0] RESP_OKAY   = 3'b000;
  localparam logic [2:0] RESP_SLVERR = 3'b010;

  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} wr_state_t;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} rd_state_t;

  // True when addr falls in [base, base + 4*depth); evaluated at 34 bits so the
  // upper limit cannot wrap.
  function automatic logic in_range(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] depth);
    logic [33:0] lim;
    lim = {2'b00, base} + {depth, 2'b00};
    return ({2'b00, addr} >= {2'b00, base}) && ({2'b00, addr} < lim);
  endfunction

endpackage

// File: rtl/axi_lite_mem_slave_if.sv
// AXI4-Lite bus bundle (AW, W, B, AR, R channels) with master/slave views.
interface axi_lite_mem_slave_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RESP_WIDTH = 3
) ();

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8:0]   wstrb;   // top bit carried on the bus but unused
  logic                    wvalid;
  logic                    wready;
  logic [RESP_WIDTH-1:0]   bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [RESP_WIDTH-1:0]   rresp;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axi_lite_mem_slave_word_ram.sv
// DEPTH x DATA_WIDTH word store: byte-enable write port, registered read port,
// synchronous clear of both the array and the read register.
module axi_lite_word_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int IDX_W      = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [IDX_W-1:0]        widx,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wbe,
  input  logic                    rd_en,
  input  logic                    rd_clr,
  input  logic [IDX_W-1:0]        ridx,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int NB = DATA_WIDTH / 8;

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;

  // Byte-masked write; read register samples pre-write contents on a same-edge hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem   <= '0;
      rdata <= '0;
    end else begin
      if (we) begin
        for (int b = 0; b < NB; b++)
          if (wbe[b]) mem[widx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
      if (rd_clr)     rdata <= '0;
      else if (rd_en) rdata <= mem[ridx];
    end
  end

endmodule

// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite register-memory responder for one address window starting at BASE_ADDR.
// Independent write (AW/W capture -> B) and read (AR -> R) state machines.
module axi_lite_mem_slave
  import axi_lite_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 8,
  parameter int          RESP_WIDTH = 3,
  parameter int          DEPTH      = 4,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                s_axi_aclk,
  input  logic                s_axi_areset,
  axi_lite_mem_slave_if.slave s_axi
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // ---- write path ----
  wr_state_t              wr_state;
  logic                   aw_got, w_got;
  logic [ADDR_WIDTH-1:0]  awaddr_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic [STRB_W-1:0]      wstrb_q;

  logic                   aw_hs, w_hs, aw_have, w_have, wr_commit, wr_ok;
  logic [ADDR_WIDTH-1:0]  wr_addr, wr_off;
  logic [DATA_WIDTH-1:0]  wr_data;
  logic [STRB_W-1:0]      wr_strb;

  assign aw_hs   = s_axi.awvalid & s_axi.awready;
  assign w_hs    = s_axi.wvalid  & s_axi.wready;
  assign aw_have = aw_got | aw_hs;
  assign w_have  = w_got  | w_hs;

  // Whatever arrives this cycle bypasses the capture registers so the commit
  // can happen on the same edge as the second half of the pair.
  assign wr_addr   = aw_got ? awaddr_q : s_axi.awaddr;
  assign wr_data   = w_got  ? wdata_q  : s_axi.wdata;
  assign wr_strb   = w_got  ? wstrb_q  : s_axi.wstrb[STRB_W-1:0];
  assign wr_commit = (wr_state == W_IDLE) & aw_have & w_have;
  assign wr_ok     = in_range(32'(wr_addr), 32'(BASE_ADDR), 32'(DEPTH));
  assign wr_off    = wr_addr - ADDR_WIDTH'(BASE_ADDR);

  // ---- read path ----
  rd_state_t              rd_state;
  logic                   ar_hs, rd_ok;
  logic [ADDR_WIDTH-1:0]  rd_off;

  assign ar_hs  = s_axi.arvalid & s_axi.arready;
  assign rd_ok  = in_range(32'(s_axi.araddr), 32'(BASE_ADDR), 32'(DEPTH));
  assign rd_off = s_axi.araddr - ADDR_WIDTH'(BASE_ADDR);

  axi_lite_word_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_ram (
    .clk    (s_axi_aclk),
    .rst    (s_axi_areset),
    .we     (wr_commit & wr_ok),
    .widx   (wr_off[IDX_W+1:2]),
    .wdata  (wr_data),
    .wbe    (wr_strb),
    .rd_en  (ar_hs & rd_ok),
    .rd_clr ((ar_hs & ~rd_ok) | (s_axi.rvalid & s_axi.rready)),
    .ridx   (rd_off[IDX_W+1:2]),
    .rdata  (s_axi.rdata)
  );

  // Write FSM: collect AW and W in any order, commit, then hold B until taken.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      wr_state      <= W_IDLE;
      aw_got        <= 1'b0;
      w_got         <= 1'b0;
      awaddr_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      s_axi.awready <= 1'b0;
      s_axi.wready  <= 1'b0;
      s_axi.bvalid  <= 1'b0;
      s_axi.bresp   <= '0;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (aw_hs) awaddr_q <= s_axi.awaddr;
          if (w_hs) begin
            wdata_q <= s_axi.wdata;
            wstrb_q <= s_axi.wstrb[STRB_W-1:0];
          end
          aw_got <= aw_have;
          w_got  <= w_have;
          if (wr_commit) begin
            wr_state      <= W_RESP;
            s_axi.bvalid  <= 1'b1;
            s_axi.bresp   <= wr_ok ? RESP_WIDTH'(RESP_OKAY) : RESP_WIDTH'(RESP_SLVERR);
            s_axi.awready <= 1'b0;
            s_axi.wready  <= 1'b0;
          end else begin
            s_axi.awready <= ~aw_have;
            s_axi.wready  <= ~w_have;
          end
        end
        W_RESP: begin
          if (s_axi.bready) begin
            wr_state      <= W_IDLE;
            aw_got        <= 1'b0;
            w_got         <= 1'b0;
            s_axi.bvalid  <= 1'b0;
            s_axi.bresp   <= '0;
            s_axi.awready <= 1'b1;
            s_axi.wready  <= 1'b1;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // Read FSM: accept AR, present data one cycle later, hold until R is taken.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      rd_state      <= R_IDLE;
      s_axi.arready <= 1'b0;
      s_axi.rvalid  <= 1'b0;
      s_axi.rresp   <= '0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (ar_hs) begin
            rd_state      <= R_DATA;
            s_axi.arready <= 1'b0;
            s_axi.rvalid  <= 1'b1;
            s_axi.rresp   <= rd_ok ? RESP_WIDTH'(RESP_OKAY) : RESP_WIDTH'(RESP_SLVERR);
          end else begin
            s_axi.arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_axi.rready) begin
            rd_state      <= R_IDLE;
            s_axi.arready <= 1'b1;
            s_axi.rvalid  <= 1'b0;
            s_axi.rresp   <= '0;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  // Address bits outside the word index and the spare strobe bit are don't-care.
  logic unused_bits;
  assign unused_bits = ^{s_axi.wstrb[STRB_W], wr_off[ADDR_WIDTH-1:IDX_W+2], wr_off[1:0],
                         rd_off[ADDR_WIDTH-1:IDX_W+2], rd_off[1:0]};

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Directed bench: instance A (BASE_ADDR=0) and instance B (BASE_ADDR=16) share
// the drive bus; sel routes valids to one of them and muxes its outputs back.
module tb_axi_lite_mem_slave;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_lite_mem_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RESP_WIDTH(3)) ia ();
  axi_lite_mem_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RESP_WIDTH(3)) ib ();

  axi_lite_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RESP_WIDTH(3), .DEPTH(4), .BASE_ADDR(0))
    dut_a (.s_axi_aclk(clk), .s_axi_areset(rst), .s_axi(ia));
  axi_lite_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RESP_WIDTH(3), .DEPTH(4), .BASE_ADDR(16))
    dut_b (.s_axi_aclk(clk), .s_axi_areset(rst), .s_axi(ib));

  // drive side
  logic        sel = 1'b0;
  logic [7:0]  awaddr = '0, araddr = '0;
  logic [31:0] wdata = '0;
  logic [4:0]  wstrb = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, bready = 1'b0, rready = 1'b0;

  assign ia.awaddr = awaddr;  assign ib.awaddr = awaddr;
  assign ia.wdata  = wdata;   assign ib.wdata  = wdata;
  assign ia.wstrb  = wstrb;   assign ib.wstrb  = wstrb;
  assign ia.araddr = araddr;  assign ib.araddr = araddr;
  assign ia.bready = bready;  assign ib.bready = bready;
  assign ia.rready = rready;  assign ib.rready = rready;
  assign ia.awvalid = awvalid & ~sel;  assign ib.awvalid = awvalid & sel;
  assign ia.wvalid  = wvalid  & ~sel;  assign ib.wvalid  = wvalid  & sel;
  assign ia.arvalid = arvalid & ~sel;  assign ib.arvalid = arvalid & sel;

  // observe side
  logic        awready, wready, bvalid, arready, rvalid;
  logic [2:0]  bresp, rresp;
  logic [31:0] rdata;
  assign awready = sel ? ib.awready : ia.awready;
  assign wready  = sel ? ib.wready  : ia.wready;
  assign bvalid  = sel ? ib.bvalid  : ia.bvalid;
  assign bresp   = sel ? ib.bresp   : ia.bresp;
  assign arready = sel ? ib.arready : ia.arready;
  assign rvalid  = sel ? ib.rvalid  : ia.rvalid;
  assign rresp   = sel ? ib.rresp   : ia.rresp;
  assign rdata   = sel ? ib.rdata   : ia.rdata;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // AW+W in the same cycle, bready high; returns bresp.
  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [4:0] s,
                    output logic [2:0] resp);
    int n = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    while (!(awready && wready) && n < 20) begin tick(); n++; end
    chk("wr_rdy", {31'd0, awready & wready}, 32'd1);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wr_bvalid", {31'd0, bvalid}, 32'd1);
    resp = bresp;
    tick();
    chk("wr_bdone", {31'd0, bvalid}, 32'd0);
    chk("wr_aw_back", {31'd0, awready}, 32'd1);
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d, output logic [2:0] resp);
    int n = 0;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    while (!arready && n < 20) begin tick(); n++; end
    chk("rd_rdy", {31'd0, arready}, 32'd1);
    tick();
    arvalid = 1'b0;
    chk("rd_rvalid", {31'd0, rvalid}, 32'd1);
    d = rdata; resp = rresp;
    tick();
    chk("rd_rdone", {31'd0, rvalid}, 32'd0);
    chk("rd_rdata_idle", rdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [2:0]  r;
    logic [31:0] d;

    // reset state
    tick(); tick();
    chk("rst_awready", {31'd0, awready}, 32'd0);
    chk("rst_wready",  {31'd0, wready},  32'd0);
    chk("rst_arready", {31'd0, arready}, 32'd0);
    chk("rst_bvalid",  {31'd0, bvalid},  32'd0);
    chk("rst_rvalid",  {31'd0, rvalid},  32'd0);
    chk("rst_rdata",   rdata, 32'd0);
    rst = 1'b0;
    tick();
    chk("post_awready", {31'd0, awready}, 32'd1);
    chk("post_wready",  {31'd0, wready},  32'd1);
    chk("post_arready", {31'd0, arready}, 32'd1);

    // 1: same-cycle AW+W, read back
    wr(8'h04, 32'd56, 5'h0F, r);       chk("t1_bresp", r, 0);
    rd(8'h04, d, r);                   chk("t1_rdata", d, 32'd56); chk("t1_rresp", r, 0);

    // 2: W two cycles ahead of AW, strobe 0x5
    wdata = 32'hAABBCCDD; wstrb = 5'h05; wvalid = 1'b1; bready = 1'b1;
    tick(); wvalid = 1'b0;
    chk("t2_wready_lo", {31'd0, wready}, 32'd0);
    chk("t2_awready_hi", {31'd0, awready}, 32'd1);
    chk("t2_no_b0", {31'd0, bvalid}, 32'd0);
    tick();
    chk("t2_no_b1", {31'd0, bvalid}, 32'd0);
    awaddr = 8'h08; awvalid = 1'b1;
    tick(); awvalid = 1'b0;
    chk("t2_bvalid", {31'd0, bvalid}, 32'd1);
    chk("t2_bresp", {29'd0, bresp}, 32'd0);
    chk("t2_awready_lo", {31'd0, awready}, 32'd0);
    tick();
    chk("t2_bdone", {31'd0, bvalid}, 32'd0);
    rd(8'h08, d, r);                   chk("t2_rdata", d, 32'h00BB00DD);

    // 3: out-of-range write/read
    wr(8'h10, 32'd64, 5'h0F, r);       chk("t3_bresp", r, 3'b010);
    rd(8'h00, d, r);                   chk("t3_w0", d, 32'd0);
    rd(8'h04, d, r);                   chk("t3_w1", d, 32'd56);
    rd(8'h08, d, r);                   chk("t3_w2", d, 32'h00BB00DD);
    rd(8'h0C, d, r);                   chk("t3_w3", d, 32'd0);
    rd(8'h10, d, r);                   chk("t3_oob_rdata", d, 32'd0); chk("t3_oob_rresp", r, 3'b010);

    // 4: backpressure on B and R
    awaddr = 8'h0C; wdata = 32'h12345678; wstrb = 5'h0F; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    tick(); awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t4_bvalid", {31'd0, bvalid}, 32'd1);
      chk("t4_bresp", {29'd0, bresp}, 32'd0);
      chk("t4_awready", {31'd0, awready}, 32'd0);
      chk("t4_wready", {31'd0, wready}, 32'd0);
      tick();
    end
    bready = 1'b1;
    tick();
    chk("t4_bdone", {31'd0, bvalid}, 32'd0);
    araddr = 8'h0C; arvalid = 1'b1; rready = 1'b0;
    tick(); arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t4_rvalid", {31'd0, rvalid}, 32'd1);
      chk("t4_rdata", rdata, 32'h12345678);
      chk("t4_rresp", {29'd0, rresp}, 32'd0);
      chk("t4_arready", {31'd0, arready}, 32'd0);
      tick();
    end
    rready = 1'b1;
    tick();
    chk("t4_rdone", {31'd0, rvalid}, 32'd0);

    // strobe corner cases: all-off, and spare MSB ignored
    wr(8'h04, 32'hFFFFFFFF, 5'h00, r); chk("strb0_bresp", r, 0);
    rd(8'h04, d, r);                   chk("strb0_rdata", d, 32'd56);
    wr(8'h0C, 32'h000000AB, 5'h11, r); chk("strbmsb_bresp", r, 0);
    rd(8'h0E, d, r);                   chk("strbmsb_rdata", d, 32'h123456AB);

    // 5: same-word read and write on the same edge
    wr(8'h00, 32'd56, 5'h0F, r);
    awaddr = 8'h00; wdata = 32'd64; wstrb = 5'h0F; araddr = 8'h00;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
    tick(); awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("t5_rvalid", {31'd0, rvalid}, 32'd1);
    chk("t5_rdata_old", rdata, 32'd56);
    chk("t5_bvalid", {31'd0, bvalid}, 32'd1);
    tick();
    rd(8'h00, d, r);                   chk("t5_rdata_new", d, 32'd64);

    // 6: reset while bvalid is held
    awaddr = 8'h04; wdata = 32'h99; wstrb = 5'h0F; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    tick(); awvalid = 1'b0; wvalid = 1'b0;
    chk("t6_bvalid_pre", {31'd0, bvalid}, 32'd1);
    rst = 1'b1;
    tick();
    chk("t6_bvalid_rst", {31'd0, bvalid}, 32'd0);
    rst = 1'b0; bready = 1'b1;
    tick(); tick(); tick();
    chk("t6_no_late_b", {31'd0, bvalid}, 32'd0);
    rd(8'h04, d, r);                   chk("t6_cleared", d, 32'd0);

    // BASE_ADDR=16 instance
    sel = 1'b1;
    wr(8'h10, 32'h77, 5'h0F, r);       chk("b_wr_bresp", r, 0);
    rd(8'h10, d, r);                   chk("b_rd_w0", d, 32'h77); chk("b_rd_rresp", r, 0);
    rd(8'h00, d, r);                   chk("b_below_rdata", d, 32'd0); chk("b_below_rresp", r, 3'b010);
    wr(8'h20, 32'h55, 5'h0F, r);       chk("b_above_bresp", r, 3'b010);
    rd(8'h1C, d, r);                   chk("b_w3", d, 32'd0); chk("b_w3_rresp", r, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
